// File: rtl/lane_seq_fsm.sv
// Moore output sequencer: walks NUM_SEL lanes holding each HOLD_CYCLES, strobes the buffer,
// with sticky illegal-state detection and a scan chain over all state flops.
module lane_seq_fsm #(
  parameter int NUM_SEL     = 4,
  parameter int HOLD_CYCLES = 1,
  localparam int SEL_W      = $clog2(NUM_SEL),
  localparam int HC_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_avail,
  input  logic             err_clr,
  input  logic             scan_en,
  input  logic             scan_in,
  output logic             scan_out,
  output logic             buf_en,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_writing,
  output logic             frame_done,
  output logic             err
);

  localparam int CHAIN_L = 3 + SEL_W + HC_W;
  localparam logic [SEL_W-1:0] LANE_MAX = SEL_W'(NUM_SEL - 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WRITE  = 3'd2,
    S_BUFFER = 3'd3,
    S_CHECK  = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t             state, state_n;
  logic [SEL_W-1:0]   lane_cnt, lane_n;
  logic [HC_W-1:0]    hold_cnt, hold_n;
  logic [CHAIN_L-1:0] chain, shifted;

  assign chain    = {state, lane_cnt, hold_cnt};
  assign shifted  = {chain[CHAIN_L-2:0], scan_in};
  assign scan_out = chain[CHAIN_L-1];

  // Shifting may load the unnamed encodings 6/7; the cast keeps them so they can be caught.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      lane_cnt <= '0;
      hold_cnt <= '0;
    end else if (scan_en) begin
      state    <= state_t'(shifted[CHAIN_L-1 -: 3]);
      lane_cnt <= shifted[HC_W +: SEL_W];
      hold_cnt <= shifted[HC_W-1:0];
    end else begin
      state    <= state_n;
      lane_cnt <= lane_n;
      hold_cnt <= hold_n;
    end
  end

  always_comb begin
    state_n = state;
    lane_n  = lane_cnt;
    hold_n  = hold_cnt;
    case (state)
      S_IDLE:   if (data_avail) state_n = S_LOAD;
      S_LOAD: begin
        state_n = S_WRITE;
        lane_n  = '0;
        hold_n  = '0;
      end
      S_WRITE: begin
        if (lane_cnt > LANE_MAX || hold_cnt > HOLD_MAX) begin
          state_n = S_ERROR;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_n = hold_cnt + HC_W'(1);
        end else begin
          hold_n = '0;
          if (lane_cnt == LANE_MAX) state_n = S_BUFFER;
          else                      lane_n  = lane_cnt + SEL_W'(1);
        end
      end
      S_BUFFER: state_n = S_CHECK;
      S_CHECK:  state_n = data_avail ? S_LOAD : S_IDLE;
      S_ERROR:  if (err_clr) state_n = S_IDLE;
      default:  state_n = S_ERROR;
    endcase
  end

  always_comb begin
    buf_en      = 1'b0;
    out_sel     = '0;
    out_writing = 1'b0;
    frame_done  = 1'b0;
    err         = 1'b0;
    case (state)
      S_IDLE: begin
        out_sel     = SEL_W'(1);
        out_writing = 1'b1;
      end
      S_LOAD: ;
      S_WRITE: begin
        out_sel     = lane_cnt;
        out_writing = 1'b1;
      end
      S_BUFFER: buf_en = 1'b1;
      S_CHECK: begin
        out_sel     = SEL_W'(1);
        out_writing = 1'b1;
        frame_done  = 1'b1;
      end
      S_ERROR:  err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lane_seq_fsm.sv
// Bench for lane_seq_fsm: two instances (4 lanes x 2 hold, 2 lanes x 1 hold) against a
// frame-position reference model, plus directed scan/illegal/reset steps.
module tb_lane_seq_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, data_avail, err_clr, scan_en_a, scan_in;
  logic a_scan_out, a_buf_en, a_out_writing, a_frame_done, a_err;
  logic [1:0] a_out_sel;
  logic b_scan_out, b_buf_en, b_out_writing, b_frame_done, b_err;
  logic [0:0] b_out_sel;

  lane_seq_fsm #(.NUM_SEL(4), .HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_avail(data_avail), .err_clr(err_clr),
    .scan_en(scan_en_a), .scan_in(scan_in), .scan_out(a_scan_out),
    .buf_en(a_buf_en), .out_sel(a_out_sel), .out_writing(a_out_writing),
    .frame_done(a_frame_done), .err(a_err));

  lane_seq_fsm #(.NUM_SEL(2), .HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_avail(data_avail), .err_clr(err_clr),
    .scan_en(1'b0), .scan_in(1'b0), .scan_out(b_scan_out),
    .buf_en(b_buf_en), .out_sel(b_out_sel), .out_writing(b_out_writing),
    .frame_done(b_frame_done), .err(b_err));

  // Model: a frame is a position count 0..n*h+2 (LOAD, n*h WRITE cycles, BUFFER, CHECK).
  localparam int M_IDLE = 0, M_FRAME = 1, M_ERR = 2, M_ILL = 3;
  int mode [2];
  int pos  [2];
  int ns   [2] = '{4, 2};
  int hc   [2] = '{2, 1};
  int passed = 0;
  int total  = 0;

  function automatic logic [6:0] expect_out(int m, int p, int n, int h);
    logic [1:0] sel;
    if (m == M_IDLE) return {1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    if (m == M_ERR)  return 7'b0000011;
    if (m == M_ILL)  return 7'b0000001;
    if (p == 0)      return 7'b0000000;
    if (p <= n * h) begin
      sel = 2'((p - 1) / h);
      return {1'b0, sel, 1'b1, 1'b0, 1'b0, 1'b0};
    end
    if (p == n * h + 1) return 7'b1000000;
    return {1'b0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1};
  endfunction

  task automatic model_step(input int d, input logic da, input logic rn, input logic ec);
    if (!rn) begin
      mode[d] = M_IDLE;
      pos[d]  = 0;
    end else begin
      case (mode[d])
        M_IDLE: if (da) begin mode[d] = M_FRAME; pos[d] = 0; end
        M_FRAME: begin
          if (pos[d] < ns[d] * hc[d] + 2) pos[d]++;
          else if (da) pos[d] = 0;
          else mode[d] = M_IDLE;
        end
        M_ERR: if (ec) mode[d] = M_IDLE;
        default: mode[d] = M_ERR;
      endcase
    end
  endtask

  task automatic tick(input bit track_a);
    @(posedge clk);
    #1;
    if (track_a) model_step(0, data_avail, rst_n, err_clr);
    model_step(1, data_avail, rst_n, err_clr);
  endtask

  task automatic check_dut(input int d, input string tag);
    logic [6:0] obs, exp;
    if (d == 0) obs = {a_buf_en, a_out_sel, a_out_writing, a_frame_done, a_err, a_scan_out};
    else        obs = {b_buf_en, 1'b0, b_out_sel, b_out_writing, b_frame_done, b_err, b_scan_out};
    exp = expect_out(mode[d], pos[d], ns[d], hc[d]);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s dut%0d: observed %b expected %b (buf,sel,wr,fd,err,so)", tag, d, obs, exp);
  endtask

  task automatic check_both(input string tag);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    logic [5:0] pat;
    int last_fd, fd_count;

    rst_n = 1'b0; data_avail = 1'b0; err_clr = 1'b0; scan_en_a = 1'b0; scan_in = 1'b0;
    mode = '{M_ERR, M_ERR}; pos = '{0, 0};

    // Reset, then idle
    tick(1);
    check_both("reset");
    rst_n = 1'b1;
    tick(1);
    check_both("idle");

    // Single frame
    data_avail = 1'b1;
    tick(1);
    check_both("frame_load");
    data_avail = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check_both("frame");
    end
    check_int("frame_end_idle", mode[0], M_IDLE);

    // Back-to-back frames: frame_done every 11 cycles on the 4x2 instance
    data_avail = 1'b1;
    last_fd = 0; fd_count = 0;
    for (int i = 1; i <= 33; i++) begin
      tick(1);
      check_both("b2b");
      if (a_frame_done === 1'b1) begin
        if (last_fd != 0) check_int("b2b_spacing", i - last_fd, 11);
        last_fd = i;
        fd_count++;
      end
    end
    check_int("b2b_count", fd_count, 3);
    data_avail = 1'b0;
    for (int i = 0; i < 13; i++) tick(1);
    check_both("b2b_drain");

    // Reset in the middle of WRITE while on lane 2
    data_avail = 1'b1;
    tick(1);
    data_avail = 1'b0;
    for (int i = 0; i < 5; i++) tick(1);
    check_both("write_lane2");
    check_int("write_lane2_sel", int'(a_out_sel), 2);
    rst_n = 1'b0;
    tick(1);
    check_both("mid_write_reset");
    rst_n = 1'b1;
    data_avail = 1'b1;
    tick(1);
    data_avail = 1'b0;
    tick(1);
    check_both("after_reset_lane0");

    // Illegal state via scan
    for (int i = 0; i < 12; i++) tick(1);
    check_both("pre_scan_idle");
    pat = 6'b110000;
    scan_en_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      scan_in = pat[5 - i];
      tick(0);
    end
    mode[0] = M_ILL;
    check_dut(0, "illegal_loaded");
    scan_en_a = 1'b0;
    tick(1);
    check_dut(0, "illegal_to_error");
    for (int i = 0; i < 3; i++) begin
      data_avail = 1'(i % 2);
      tick(1);
      check_both("error_sticky");
    end
    data_avail = 1'b0;
    err_clr = 1'b1;
    tick(1);
    check_both("error_clear");
    err_clr = 1'b0;

    // Scan round trip: 101010 in, then out while shifting zeros; FSM inputs must be ignored
    pat = 6'b101010;
    scan_en_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      scan_in = pat[5 - i];
      tick(0);
    end
    mode[0] = M_ERR;
    check_dut(0, "scan_loaded_error");
    err_clr = 1'b1;
    data_avail = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_bit($sformatf("scan_out_bit%0d", i), a_scan_out, pat[5 - i]);
      scan_in = 1'b0;
      tick(0);
    end
    mode[0] = M_IDLE;
    check_dut(0, "scan_zero_idle");
    scan_en_a = 1'b0;
    err_clr = 1'b0;
    data_avail = 1'b0;
    tick(1);
    check_both("scan_resume");

    // Randomized traffic with occasional reset and error-clear
    for (int i = 0; i < 400; i++) begin
      data_avail = 1'($urandom_range(0, 1));
      err_clr    = 1'($urandom_range(0, 1));
      rst_n      = ($urandom_range(0, 24) != 0);
      tick(1);
      check_both("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
